// File: rtl/sram_mem_responder.sv
// MEM-stage data-memory responder: one 32-bit word per request, as two half-word
// accesses to an asynchronous 16-bit SRAM. Optional last-word buffer: SRAM_LAST_WORD_BUF_EN.
module sram_mem_responder #(
  parameter int ACCESS_CYCLES = 2,
  parameter int ADDR_OFFSET   = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rd_en,
  input  logic        wr_en,
  input  logic [31:0] address,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  output logic        ready,
  output logic [17:0] sram_addr,
  inout  wire  [15:0] sram_dq,
  output logic        sram_we_n,
  output logic        sram_oe_n,
  output logic        sram_ce_n,
  output logic        sram_ub_n,
  output logic        sram_lb_n
);

  localparam int            CW     = $clog2(ACCESS_CYCLES);
  localparam logic [CW-1:0] LAST   = CW'(ACCESS_CYCLES - 1);
  localparam logic [31:0]   OFFSET = 32'(ADDR_OFFSET);

  typedef enum logic [2:0] {IDLE, WR_LO, WR_HI, RD_LO, RD_HI, DONE} state_t;

  state_t        state, state_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic [16:0]   word_q, word_nx, req_word;
  logic [31:0]   wdata_q, wdata_nx;
  logic [15:0]   dq_out;
  logic          dq_oe;
  logic          hit;
  logic [31:0]   hit_data;

  // Only the low 17 bits of the offset-adjusted address survive, so the modular
  // difference of the low bits is enough once the below-offset case is clamped.
  assign req_word = (address >= OFFSET) ? (address[16:0] - OFFSET[16:0]) : 17'd0;

  assign sram_ub_n = 1'b0;
  assign sram_lb_n = 1'b0;
  assign sram_dq   = dq_oe ? dq_out : 16'hzzzz;

`ifdef SRAM_LAST_WORD_BUF_EN
  logic        buf_valid;
  logic [16:0] buf_word;
  logic [31:0] buf_data;

  assign hit      = rd_en && !wr_en && buf_valid && (buf_word == req_word);
  assign hit_data = buf_data;

  // The entry tracks the most recently completed access of either kind.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      buf_valid <= 1'b0;
      buf_word  <= '0;
      buf_data  <= '0;
    end else if (state == WR_HI && cnt == LAST) begin
      buf_valid <= 1'b1;
      buf_word  <= word_q;
      buf_data  <= wdata_q;
    end else if (state == RD_HI && cnt == LAST) begin
      buf_valid <= 1'b1;
      buf_word  <= word_q;
      buf_data  <= {sram_dq, read_data[15:0]};
    end
  end
`else
  assign hit      = 1'b0;
  assign hit_data = '0;
`endif

  always_comb begin
    case (state)
      IDLE:    ready = !(rd_en || wr_en);
      DONE:    ready = 1'b1;
      default: ready = 1'b0;
    endcase
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    word_nx  = word_q;
    wdata_nx = wdata_q;
    case (state)
      IDLE: begin
        if (wr_en || rd_en) begin
          word_nx  = req_word;
          wdata_nx = write_data;
          cnt_nx   = '0;
          if (wr_en)    state_nx = WR_LO;
          else if (hit) state_nx = DONE;
          else          state_nx = RD_LO;
        end
      end
      WR_LO, WR_HI, RD_LO, RD_HI: begin
        if (cnt == LAST) begin
          cnt_nx = '0;
          case (state)
            WR_LO:   state_nx = WR_HI;
            RD_LO:   state_nx = RD_HI;
            default: state_nx = DONE;
          endcase
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // SRAM pins come from the next-state values so they are settled for the whole
  // phase; WE rises on the last phase cycle while address and data stay put.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      word_q    <= '0;
      wdata_q   <= '0;
      read_data <= '0;
      sram_addr <= '0;
      sram_we_n <= 1'b1;
      sram_oe_n <= 1'b1;
      sram_ce_n <= 1'b1;
      dq_oe     <= 1'b0;
      dq_out    <= '0;
    end else begin
      state     <= state_nx;
      cnt       <= cnt_nx;
      word_q    <= word_nx;
      wdata_q   <= wdata_nx;
      sram_ce_n <= !(state_nx inside {WR_LO, WR_HI, RD_LO, RD_HI});
      sram_oe_n <= !(state_nx inside {RD_LO, RD_HI});
      sram_we_n <= !((state_nx inside {WR_LO, WR_HI}) && (cnt_nx != LAST));
      dq_oe     <= state_nx inside {WR_LO, WR_HI};
      dq_out    <= (state_nx == WR_HI) ? wdata_nx[31:16] : wdata_nx[15:0];
      if (state_nx inside {WR_LO, WR_HI, RD_LO, RD_HI})
        sram_addr <= {word_nx, (state_nx == WR_HI) || (state_nx == RD_HI)};
      if (state == RD_LO && cnt == LAST) read_data[15:0]  <= sram_dq;
      if (state == RD_HI && cnt == LAST) read_data[31:16] <= sram_dq;
      if (state == IDLE && hit)          read_data        <= hit_data;
    end
  end

endmodule
